// File: rtl/int_ctrl_if.sv
// CPU-side register bus for int_ctrl: word address, byte enables, write/read strobes and data.
// The controller takes the slave side; the CPU or bench drives the master side.

interface int_ctrl_if;
    logic [31:2] PrAddr;
    logic [3:0]  BE;
    logic [31:0] PrWD;
    logic        Wen;
    logic        Ren;
    logic [31:0] PrRD;

    modport master (
        output PrAddr,
        output BE,
        output PrWD,
        output Wen,
        output Ren,
        input  PrRD
    );

    modport slave (
        input  PrAddr,
        input  BE,
        input  PrWD,
        input  Wen,
        input  Ren,
        output PrRD
    );
endinterface

// File: rtl/int_ctrl.sv
// Six-source interrupt controller: per-source mask and edge/level mode, fixed priority
// (lowest index wins), single-level claim/EOI handshake and a registered HWInt request.

module int_ctrl #(
    parameter logic [31:0] BASE = 32'h00007F20
) (
    input  logic       clk,
    input  logic       reset,
    int_ctrl_if.slave  bus,
    input  logic [5:0] IrqSrc,
    output logic [5:0] HWInt
);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StInserv
    } state_e;

    localparam logic [1:0] OffMask  = 2'd0;
    localparam logic [1:0] OffPend  = 2'd1;
    localparam logic [1:0] OffMode  = 2'd2;
    localparam logic [1:0] OffClaim = 2'd3;

    state_e     r_state;
    state_e     w_state_d;
    logic [5:0] r_mask;
    logic [5:0] r_pend;
    logic [5:0] r_mode;
    logic [5:0] r_sample;
    logic [5:0] r_hwint;
    logic [2:0] r_isr_id;

    logic [5:0] w_mask_d;
    logic [5:0] w_pend_d;
    logic [5:0] w_mode_d;
    logic [5:0] w_hwint_d;
    logic [2:0] w_isr_id_d;

    logic       w_sel;
    logic [1:0] w_off;
    logic       w_wr_en;
    logic       w_rd_en;
    logic [5:0] w_active;
    logic [2:0] w_id;
    logic [5:0] w_edge;
    logic [5:0] w_w1c;
    logic [5:0] w_claim_clr;
    logic       w_claim;
    logic       w_eoi;
    logic       w_unused_bits;

    function automatic logic [2:0] prio_id(input logic [5:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
                id = 3'(i);
            end
        end
        return id;
    endfunction

    function automatic logic [5:0] onehot(input logic [2:0] id);
        return 6'd1 << id;
    endfunction

    // Address decode; only byte lane 0 carries register bits.
    assign w_sel         = (bus.PrAddr[31:4] == BASE[31:4]);
    assign w_off         = bus.PrAddr[3:2];
    assign w_wr_en       = bus.Wen & w_sel & bus.BE[0];
    assign w_rd_en       = bus.Ren & w_sel;
    assign w_unused_bits = ^{bus.PrWD[31:6], bus.BE[3:1]};

    assign w_active = r_pend & r_mask;
    assign w_id     = prio_id(w_active);
    assign w_edge   = IrqSrc & ~r_sample;

    assign w_claim = w_rd_en && (w_off == OffClaim) && (r_state == StAssert) && (|w_active);
    assign w_eoi   = w_wr_en && (w_off == OffClaim) && (r_state == StInserv);

    // A claim only retires the pending bit of an edge-mode source.
    assign w_claim_clr = w_claim ? (onehot(w_id) & r_mode) : 6'd0;

    always_comb begin
        w_mask_d = r_mask;
        w_mode_d = r_mode;
        w_w1c    = 6'd0;
        if (w_wr_en) begin
            case (w_off)
                OffMask: w_mask_d = bus.PrWD[5:0];
                OffPend: w_w1c    = bus.PrWD[5:0];
                OffMode: w_mode_d = bus.PrWD[5:0];
                default: ;
            endcase
        end
    end

    // Edge bits: new edges beat W1C and claim clears. Level bits: follow the line.
    assign w_pend_d = (r_mode & ((r_pend & ~w_w1c & ~w_claim_clr) | w_edge))
                    | (~r_mode & IrqSrc);

    always_comb begin
        w_state_d  = r_state;
        w_hwint_d  = 6'd0;
        w_isr_id_d = r_isr_id;
        case (r_state)
            StIdle: begin
                if (|w_active) begin
                    w_state_d = StAssert;
                    w_hwint_d = onehot(w_id);
                end
            end
            StAssert: begin
                if (w_claim) begin
                    w_state_d  = StInserv;
                    w_isr_id_d = w_id;
                end else if (!(|w_active)) begin
                    w_state_d = StIdle;
                end else begin
                    w_hwint_d = onehot(w_id);
                end
            end
            StInserv: begin
                if (w_eoi) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.PrRD = 32'd0;
        if (w_sel) begin
            case (w_off)
                OffMask: bus.PrRD = {26'd0, r_mask};
                OffPend: bus.PrRD = {26'd0, r_pend};
                OffMode: bus.PrRD = {26'd0, r_mode};
                default: begin
                    case (r_state)
                        StAssert: bus.PrRD = (|w_active) ? {29'd0, w_id} : 32'h0000_0007;
                        StInserv: bus.PrRD = {1'b1, 28'd0, r_isr_id};
                        default:  bus.PrRD = 32'h0000_0007;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_mask   <= 6'd0;
            r_pend   <= 6'd0;
            r_mode   <= 6'd0;
            r_sample <= 6'd0;
            r_hwint  <= 6'd0;
            r_isr_id <= 3'd0;
        end else begin
            r_state  <= w_state_d;
            r_mask   <= w_mask_d;
            r_pend   <= w_pend_d;
            r_mode   <= w_mode_d;
            r_sample <= IrqSrc;
            r_hwint  <= w_hwint_d;
            r_isr_id <= w_isr_id_d;
        end
    end

    assign HWInt = r_hwint;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl: edge path, priority, level/mask, boundary cases
// and asynchronous reset out of service.

module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h00007F20;

    logic       clk;
    logic       reset;
    logic [5:0] IrqSrc;
    logic [5:0] HWInt;
    logic [31:0] d;
    int         n_checks;
    int         n_errors;

    int_ctrl_if bus ();

    int_ctrl #(
        .BASE(BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .IrqSrc(IrqSrc),
        .HWInt (HWInt)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [1:0] off, output logic [31:0] v);
        bus.PrAddr = {BASE[31:4], off};
        #1;
        v = bus.PrRD;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] v;
        peek(off, v);
        chk(tag, v, exp);
    endtask

    task automatic chk_hw(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, HWInt}, {26'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_at(input logic [31:2] a, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        bus.PrAddr = a;
        bus.PrWD   = data;
        bus.BE     = be;
        bus.Wen    = 1'b1;
        tick();
        bus.Wen = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
        wr_at({BASE[31:4], off}, data, be);
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] v);
        @(negedge clk);
        bus.PrAddr = {BASE[31:4], off};
        bus.Ren    = 1'b1;
        #1;
        v = bus.PrRD;
        tick();
        bus.Ren = 1'b0;
    endtask

    // One-cycle pulse on the given lines, then one more edge so HWInt has been updated.
    task automatic pulse(input logic [5:0] v);
        @(negedge clk);
        IrqSrc = v;
        tick();
        @(negedge clk);
        IrqSrc = 6'd0;
        tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        IrqSrc     = 6'd0;
        bus.PrAddr = {BASE[31:4], 2'd0};
        bus.BE     = 4'h0;
        bus.PrWD   = 32'd0;
        bus.Wen    = 1'b0;
        bus.Ren    = 1'b0;
        #3;

        chk_hw("rst_hwint", 6'd0);
        chk_reg("rst_mask", 2'd0, 32'd0);
        chk_reg("rst_pend", 2'd1, 32'd0);
        chk_reg("rst_mode", 2'd2, 32'd0);
        chk_reg("rst_claim", 2'd3, 32'h0000_0007);
        @(negedge clk);
        reset = 1'b0;

        // Edge path on source 3
        wr(2'd0, 32'h3F, 4'hF);
        wr(2'd2, 32'h3F, 4'hF);
        chk_reg("mask_rw", 2'd0, 32'h3F);
        chk_reg("mode_rw", 2'd2, 32'h3F);
        @(negedge clk);
        IrqSrc = 6'b001000;
        tick();
        chk_reg("edge_pend", 2'd1, 32'h08);
        chk_hw("edge_hw_k", 6'd0);
        @(negedge clk);
        IrqSrc = 6'd0;
        tick();
        chk_hw("edge_hw_k1", 6'b001000);
        rd(2'd3, d);
        chk("edge_claim", d, 32'd3);
        chk_hw("edge_hw_claimed", 6'd0);
        chk_reg("edge_pend_clr", 2'd1, 32'd0);
        chk_reg("edge_inserv", 2'd3, 32'h8000_0003);
        wr(2'd3, 32'd0, 4'hF);
        chk_reg("edge_eoi", 2'd3, 32'h0000_0007);

        // Priority: sources 4 and 1 together
        pulse(6'b010010);
        chk_hw("prio_hw1", 6'b000010);
        chk_reg("prio_pend", 2'd1, 32'h12);
        rd(2'd3, d);
        chk("prio_claim1", d, 32'd1);
        chk_reg("prio_pend_held", 2'd1, 32'h10);
        chk_hw("prio_inserv_hw", 6'd0);
        wr(2'd3, 32'd0, 4'hF);
        tick();
        chk_hw("prio_hw2", 6'b010000);
        rd(2'd3, d);
        chk("prio_claim2", d, 32'd4);
        wr(2'd3, 32'd0, 4'hF);

        // Level mode with only source 0 unmasked
        wr(2'd2, 32'h00, 4'hF);
        wr(2'd0, 32'h01, 4'hF);
        @(negedge clk);
        IrqSrc = 6'b000101;
        tick();
        tick();
        chk_hw("lvl_hw", 6'b000001);
        chk_reg("lvl_pend", 2'd1, 32'h05);
        rd(2'd3, d);
        chk("lvl_claim", d, 32'd0);
        chk_hw("lvl_hw_claimed", 6'd0);
        chk_reg("lvl_pend_kept", 2'd1, 32'h05);
        wr(2'd3, 32'd0, 4'hF);
        tick();
        chk_hw("lvl_reassert", 6'b000001);
        @(negedge clk);
        IrqSrc = 6'd0;
        tick();
        tick();
        chk_hw("lvl_drop_hw", 6'd0);
        chk_reg("lvl_drop_idle", 2'd3, 32'h0000_0007);

        // Boundaries
        rd(2'd3, d);
        chk("idle_claim", d, 32'h0000_0007);
        chk_reg("idle_claim_pend", 2'd1, 32'd0);
        wr(2'd2, 32'h3F, 4'hF);
        wr(2'd0, 32'h00, 4'hF);
        pulse(6'b100000);
        chk_reg("w1c_pre", 2'd1, 32'h20);
        @(negedge clk);
        IrqSrc     = 6'b100000;
        bus.PrAddr = {BASE[31:4], 2'd1};
        bus.PrWD   = 32'h20;
        bus.BE     = 4'hF;
        bus.Wen    = 1'b1;
        tick();
        bus.Wen = 1'b0;
        IrqSrc  = 6'd0;
        chk_reg("w1c_vs_set", 2'd1, 32'h20);
        wr(2'd1, 32'h20, 4'hF);
        chk_reg("w1c_only", 2'd1, 32'd0);
        wr(2'd0, 32'hFFFF_FF15, 4'b1110);
        chk_reg("be_upper_mask", 2'd0, 32'd0);
        wr(2'd0, 32'hFFFF_FF15, 4'b0001);
        chk_reg("be0_mask", 2'd0, 32'h15);
        wr_at({BASE[31:4] + 28'd1, 2'd0}, 32'h3F, 4'hF);
        chk_reg("unsel_wr_mask", 2'd0, 32'h15);
        bus.PrAddr = {BASE[31:4] + 28'd1, 2'd0};
        #1;
        chk("unsel_rd", bus.PrRD, 32'd0);

        // Reset while in service
        wr(2'd0, 32'h3F, 4'hF);
        pulse(6'b000100);
        chk_hw("rst_pre_hw", 6'b000100);
        rd(2'd3, d);
        chk("rst_pre_claim2", d, 32'd2);
        pulse(6'b010000);
        chk_reg("rst_pre_pend", 2'd1, 32'h10);
        chk_reg("rst_pre_inserv", 2'd3, 32'h8000_0002);
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_hw("rst_async_hw", 6'd0);
        chk_reg("rst_async_mask", 2'd0, 32'd0);
        chk_reg("rst_async_pend", 2'd1, 32'd0);
        chk_reg("rst_async_mode", 2'd2, 32'd0);
        chk_reg("rst_async_claim", 2'd3, 32'h0000_0007);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk_hw("rst_after_hw", 6'd0);
        chk_reg("rst_after_claim", 2'd3, 32'h0000_0007);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
